// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite display scheduler.
// Contents: slot FSM state enum, read-address field widths, slot count.
package sprite_sched_pkg;

    localparam int unsigned NUM_SLOTS = 2;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned INDEX_W   = 10;
    localparam int unsigned SLOT_W    = 1;
    localparam int unsigned BANK_W    = 1;
    localparam int unsigned ADDR_W    = BANK_W + SLOT_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOADING = 2'b01,
        PENDING = 2'b10
    } slot_state_t;

endpackage

// File: rtl/sprite_bank_fsm.sv
// Per-slot load sequencer: tracks loader progress and owns the front-bank bit.
// The front bank only flips on a frame_start that finds the slot PENDING.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   frame_start  - start of vertical blank
//   load_start   - loader begins filling this slot
//   load_done    - loader finished this slot
//   state        - current FSM state (registered)
//   front_bank   - bank read by scan-out (registered); loader uses the other
module sprite_bank_fsm
    import sprite_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        load_start,
    input  logic        load_done,
    output slot_state_t state,
    output logic        front_bank
);

    slot_state_t state_next;
    logic        front_next;

    // State and bank registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            front_bank <= 1'b0;
        end else begin
            state      <= state_next;
            front_bank <= front_next;
        end
    end

    // Next state; load_start always wins over load_done/frame_start
    always_comb begin
        state_next = state;
        front_next = front_bank;
        case (state)
            IDLE: begin
                if (load_start) state_next = LOADING;
            end
            LOADING: begin
                if (load_start)     state_next = LOADING;
                else if (load_done) state_next = PENDING;
            end
            PENDING: begin
                if (load_start) begin
                    state_next = LOADING;
                end else if (frame_start) begin
                    state_next = IDLE;
                    front_next = ~front_bank;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/sprite_display_scheduler.sv
// Sprite RAM sequencer and placer for two sprites (slot 1 drawn over slot 0).
// Ping-pongs each slot's RAM banks between loader and scan-out, hit-tests the
// scan position, issues RAM read addresses and aligns the returned pixel.
// Optional macro SPRITE_MIRROR_EN adds a per-slot horizontal flip.
// Ports:
//   vgaclk, reset_n            - pixel clock, async active-low reset
//   x, y                       - current scan position
//   frame_start                - start of vertical blank
//   load_start/done, load_slot - loader handshake pulses
//   pos_we, pos_slot, pos_x, pos_y, pos_flip - position shadow write
//   wr_bank                    - loader bank per slot
//   rd_addr                    - {bank, slot, index} to RAM read port
//   pixel_q                    - RAM read data
//   pal_idx, pix_valid         - aligned palette index and opaque flag
//   slot_state                 - {slot1, slot0} FSM states
module sprite_display_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int unsigned SPRITEWIDTH  = 32,
    parameter int unsigned BITSPERPIXEL = 4,
    parameter int unsigned RAM_LATENCY  = 1
) (
    input  logic                    vgaclk,
    input  logic                    reset_n,
    input  logic [COORD_W-1:0]      x,
    input  logic [COORD_W-1:0]      y,
    input  logic                    frame_start,
    input  logic                    load_start,
    input  logic                    load_done,
    input  logic                    load_slot,
    input  logic                    pos_we,
    input  logic                    pos_slot,
    input  logic [COORD_W-1:0]      pos_x,
    input  logic [COORD_W-1:0]      pos_y,
    input  logic                    pos_flip,
    output logic [NUM_SLOTS-1:0]    wr_bank,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [BITSPERPIXEL-1:0] pixel_q,
    output logic [BITSPERPIXEL-1:0] pal_idx,
    output logic                    pix_valid,
    output logic [3:0]              slot_state
);

    localparam int unsigned COL_W = $clog2(SPRITEWIDTH);

    slot_state_t         state      [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] front_bank;
    logic [COORD_W-1:0]  shadow_x   [NUM_SLOTS];
    logic [COORD_W-1:0]  shadow_y   [NUM_SLOTS];
    logic [COORD_W-1:0]  active_x   [NUM_SLOTS];
    logic [COORD_W-1:0]  active_y   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] hit;
    logic [INDEX_W-1:0]  idx        [NUM_SLOTS];
    logic                sel_hit;
    logic [SLOT_W-1:0]   sel_slot;
    logic [ADDR_W-1:0]   next_addr;
    logic [RAM_LATENCY:0] hit_pipe;
    logic                out_valid;

`ifdef SPRITE_MIRROR_EN
    logic [NUM_SLOTS-1:0] shadow_flip;
    logic [NUM_SLOTS-1:0] active_flip;
`else
    logic unused_flip;
    assign unused_flip = pos_flip;
`endif

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        logic [COORD_W:0] end_x;
        logic [COORD_W:0] end_y;
        logic [COL_W-1:0] dx;
        logic [COL_W-1:0] dy;
        logic [COL_W-1:0] col;

        sprite_bank_fsm u_fsm (
            .clk         (vgaclk),
            .rst_n       (reset_n),
            .frame_start (frame_start),
            .load_start  (load_start && (load_slot == 1'(s))),
            .load_done   (load_done && (load_slot == 1'(s))),
            .state       (state[s]),
            .front_bank  (front_bank[s])
        );

        // Hit window in 11 bits so positions near the edge clip, never wrap
        assign end_x  = 11'(active_x[s]) + 11'(SPRITEWIDTH);
        assign end_y  = 11'(active_y[s]) + 11'(SPRITEWIDTH);
        assign hit[s] = (x >= active_x[s]) && (11'(x) < end_x) &&
                        (y >= active_y[s]) && (11'(y) < end_y);

        assign dx = COL_W'(x - active_x[s]);
        assign dy = COL_W'(y - active_y[s]);
`ifdef SPRITE_MIRROR_EN
        // ~dx equals SPRITEWIDTH-1-dx for a power-of-two width
        assign col = active_flip[s] ? ~dx : dx;
`else
        assign col = dx;
`endif
        assign idx[s] = INDEX_W'({dy, col});
    end

    assign wr_bank    = ~front_bank;
    assign slot_state = {state[1], state[0]};

    // Slot 1 has priority; no fall-through to slot 0 on transparency
    always_comb begin
        sel_hit   = |hit;
        sel_slot  = SLOT_W'(hit[1]);
        next_addr = {front_bank[sel_slot], sel_slot, idx[sel_slot]};
    end

    // Position shadows; a write coinciding with frame_start goes live at once
    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                shadow_x[s] <= '0;
                shadow_y[s] <= '0;
                active_x[s] <= '0;
                active_y[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (pos_we && (pos_slot == 1'(s))) begin
                    shadow_x[s] <= pos_x;
                    shadow_y[s] <= pos_y;
                end
                if (frame_start) begin
                    active_x[s] <= (pos_we && (pos_slot == 1'(s))) ? pos_x : shadow_x[s];
                    active_y[s] <= (pos_we && (pos_slot == 1'(s))) ? pos_y : shadow_y[s];
                end
            end
        end
    end

`ifdef SPRITE_MIRROR_EN
    // Flip bit follows the same shadow/active discipline as the position
    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_flip <= '0;
            active_flip <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (pos_we && (pos_slot == 1'(s))) shadow_flip[s] <= pos_flip;
                if (frame_start)
                    active_flip[s] <= (pos_we && (pos_slot == 1'(s))) ? pos_flip : shadow_flip[s];
            end
        end
    end
`endif

    assign out_valid = hit_pipe[RAM_LATENCY] && (pixel_q != '0);

    // Address register, hit delay line matched to RAM latency, output stage
    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr   <= '0;
            hit_pipe  <= '0;
            pal_idx   <= '0;
            pix_valid <= 1'b0;
        end else begin
            if (sel_hit) rd_addr <= next_addr;
            hit_pipe[0] <= sel_hit;
            for (int i = 1; i <= RAM_LATENCY; i++) hit_pipe[i] <= hit_pipe[i-1];
            pix_valid <= out_valid;
            pal_idx   <= out_valid ? pixel_q : '0;
        end
    end

endmodule

// File: tb/tb_sprite_display_scheduler.sv
// Directed bench for sprite_display_scheduler with a 1-cycle RAM model.
// RAM content: index mod 16, except slot 1 indices below 64 read as 0.
module tb_sprite_display_scheduler;

    logic        vgaclk = 1'b0;
    logic        reset_n;
    logic [9:0]  x, y;
    logic        frame_start, load_start, load_done, load_slot;
    logic        pos_we, pos_slot, pos_flip;
    logic [9:0]  pos_x, pos_y;
    logic [1:0]  wr_bank;
    logic [11:0] rd_addr;
    logic [3:0]  pixel_q;
    logic [3:0]  pal_idx;
    logic        pix_valid;
    logic [3:0]  slot_state;

    int checks = 0;
    int errors = 0;

    always #5 vgaclk = ~vgaclk;

    sprite_display_scheduler dut (
        .vgaclk      (vgaclk),
        .reset_n     (reset_n),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .load_start  (load_start),
        .load_done   (load_done),
        .load_slot   (load_slot),
        .pos_we      (pos_we),
        .pos_slot    (pos_slot),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_flip    (pos_flip),
        .wr_bank     (wr_bank),
        .rd_addr     (rd_addr),
        .pixel_q     (pixel_q),
        .pal_idx     (pal_idx),
        .pix_valid   (pix_valid),
        .slot_state  (slot_state)
    );

    function automatic logic [3:0] ram_data(input logic [11:0] a);
        if (a[10] && (a[9:0] < 10'd64)) return 4'd0;
        return a[3:0];
    endfunction

    always @(posedge vgaclk) pixel_q <= ram_data(rd_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic pulse_load(input logic start, input logic done, input logic slot);
        load_slot = slot; load_start = start; load_done = done;
        tick();
        load_start = 1'b0; load_done = 1'b0;
    endtask

    task automatic write_pos(input logic slot, input int px, input int py, input logic flip);
        pos_we = 1'b1; pos_slot = slot; pos_x = 10'(px); pos_y = 10'(py); pos_flip = flip;
        tick();
        pos_we = 1'b0; pos_flip = 1'b0;
    endtask

    task automatic set_xy(input int px, input int py);
        x = 10'(px); y = 10'(py);
    endtask

    initial begin
        reset_n = 1'b0; frame_start = 0; load_start = 0; load_done = 0; load_slot = 0;
        pos_we = 0; pos_slot = 0; pos_x = 0; pos_y = 0; pos_flip = 0;
        set_xy(700, 500);
        #3;
        check("rst_wr_bank", 32'(wr_bank), 32'd3);
        check("rst_state", 32'(slot_state), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_pal", 32'(pal_idx), 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Two idle frames
        for (int f = 0; f < 2; f++) begin
            pulse_frame();
            repeat (4) tick();
            check("idle_valid", 32'(pix_valid), 32'd0);
            check("idle_wr_bank", 32'(wr_bank), 32'd3);
            check("idle_state", 32'(slot_state), 32'd0);
        end

        // Shadow writes must not take effect before frame_start
        write_pos(1'b0, 100, 50, 1'b0);
        write_pos(1'b1, 300, 300, 1'b0);
        set_xy(103, 52);
        repeat (3) tick();
        check("shadow_valid", 32'(pix_valid), 32'd0);
        check("shadow_rd_addr", 32'(rd_addr), 32'd0);
        set_xy(700, 500);
        repeat (3) tick();

        // Load slot 0 and swap on frame
        pulse_load(1'b1, 1'b0, 1'b0);
        check("load_state", 32'(slot_state), 32'd1);
        check("load_wr_bank", 32'(wr_bank), 32'd3);
        pulse_load(1'b0, 1'b1, 1'b0);
        check("pend_state", 32'(slot_state), 32'd2);
        tick();
        check("pend_wr_bank", 32'(wr_bank), 32'd3);
        pulse_frame();
        check("swap_wr_bank", 32'(wr_bank), 32'd2);
        check("swap_state", 32'(slot_state), 32'd0);

        // Position and latency for slot 0 at (100,50), front bank 1
        set_xy(103, 52);
        tick();
        check("pos_rd_addr", 32'(rd_addr), 32'd2115);
        tick();
        check("lat2_valid", 32'(pix_valid), 32'd0);
        tick();
        check("lat3_valid", 32'(pix_valid), 32'd1);
        check("lat3_pal", 32'(pal_idx), 32'd3);
        set_xy(132, 52);
        tick();
        check("miss_rd_hold", 32'(rd_addr), 32'd2115);
        tick(); tick();
        check("miss_valid", 32'(pix_valid), 32'd0);
        check("miss_pal", 32'(pal_idx), 32'd0);
        set_xy(131, 81);
        tick();
        check("corner_rd_addr", 32'(rd_addr), 32'd3071);
        tick(); tick();
        check("corner_pal", 32'(pal_idx), 32'd15);
        check("corner_valid", 32'(pix_valid), 32'd1);
        set_xy(700, 500);

        // load_done and frame_start together: stay PENDING, swap next frame
        pulse_load(1'b1, 1'b0, 1'b0);
        load_done = 1'b1; load_slot = 1'b0; frame_start = 1'b1;
        tick();
        load_done = 1'b0; frame_start = 1'b0;
        check("coll_state", 32'(slot_state), 32'd2);
        check("coll_wr_bank", 32'(wr_bank), 32'd2);
        pulse_frame();
        check("coll_swap_bank", 32'(wr_bank), 32'd3);
        check("coll_swap_state", 32'(slot_state), 32'd0);

        // load_start beats load_done; load_start in PENDING cancels swap
        pulse_load(1'b1, 1'b1, 1'b0);
        check("start_wins", 32'(slot_state), 32'd1);
        pulse_load(1'b0, 1'b1, 1'b0);
        pulse_load(1'b1, 1'b0, 1'b0);
        check("cancel_state", 32'(slot_state), 32'd1);
        pulse_frame();
        check("cancel_bank", 32'(wr_bank), 32'd3);
        check("cancel_loading", 32'(slot_state), 32'd1);
        pulse_load(1'b0, 1'b1, 1'b0);
        pulse_frame();
        check("reswap_bank", 32'(wr_bank), 32'd2);
        pulse_load(1'b0, 1'b1, 1'b0);
        check("done_idle_ignored", 32'(slot_state), 32'd0);

        // Overlap: both at (0,0); slot 1 front bank 0, slot 0 front bank 1
        write_pos(1'b0, 0, 0, 1'b0);
        write_pos(1'b1, 0, 0, 1'b0);
        pulse_frame();
        set_xy(5, 0);
        tick();
        check("ovl_rd_addr", 32'(rd_addr), 32'd1029);
        tick(); tick();
        check("ovl_transp_valid", 32'(pix_valid), 32'd0);
        check("ovl_transp_pal", 32'(pal_idx), 32'd0);
        set_xy(5, 3);
        tick();
        check("ovl2_rd_addr", 32'(rd_addr), 32'd1125);
        tick(); tick();
        check("ovl2_pal", 32'(pal_idx), 32'd5);
        check("ovl2_valid", 32'(pix_valid), 32'd1);

        // Mid-frame shadow write keeps slot 1 in place
        write_pos(1'b1, 400, 400, 1'b0);
        repeat (3) tick();
        check("mid_rd_addr", 32'(rd_addr), 32'd1125);
        check("mid_valid", 32'(pix_valid), 32'd1);

        // pos_we on the frame_start edge is live immediately
        frame_start = 1'b1;
        write_pos(1'b0, 200, 200, 1'b0);
        frame_start = 1'b0;
        tick(); tick(); tick();
        check("moved_valid", 32'(pix_valid), 32'd0);
        set_xy(201, 200);
        tick();
        check("same_edge_rd", 32'(rd_addr), 32'd2049);
        tick(); tick();
        check("same_edge_pal", 32'(pal_idx), 32'd1);

        // Flip request at top-left corner
        frame_start = 1'b1;
        write_pos(1'b0, 200, 200, 1'b1);
        frame_start = 1'b0;
        set_xy(200, 200);
        tick();
`ifdef SPRITE_MIRROR_EN
        check("mirror_rd_addr", 32'(rd_addr), 32'd2079);
        tick(); tick();
        check("mirror_pal", 32'(pal_idx), 32'd15);
`else
        check("noflip_rd_addr", 32'(rd_addr), 32'd2048);
        tick(); tick();
        check("noflip_valid", 32'(pix_valid), 32'd0);
`endif

        // Reset in the middle of a slot 1 load
        pulse_load(1'b1, 1'b0, 1'b1);
        check("slot1_loading", 32'(slot_state), 32'd4);
        reset_n = 1'b0;
        #1;
        check("midrst_wr_bank", 32'(wr_bank), 32'd3);
        check("midrst_state", 32'(slot_state), 32'd0);
        check("midrst_rd_addr", 32'(rd_addr), 32'd0);
        check("midrst_valid", 32'(pix_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
